// File: rtl/icache_refill_ctrl.sv
// ICache miss refill controller: accepts one miss, reads the line from memory
// beat by beat, assembles it and hands the full line back to the ICache.
module icache_refill_ctrl #(
  parameter int PLEN       = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BUS_WIDTH  = 64,
  parameter int WAY_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_req_valid_i,
  output logic                  miss_req_ready_o,
  input  logic [PLEN-1:0]       miss_req_paddr_i,
  input  logic [WAY_WIDTH-1:0]  miss_req_victim_way_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PLEN-1:0]       mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,
  input  logic [BUS_WIDTH-1:0]  mem_rsp_data_i,
  input  logic                  mem_rsp_last_i,
  output logic                  refill_valid_o,
  input  logic                  refill_ready_i,
  output logic [PLEN-1:0]       refill_paddr_o,
  output logic [WAY_WIDTH-1:0]  refill_way_o,
  output logic [LINE_WIDTH-1:0] refill_data_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [31:0]           refill_count_o
);

  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, FILL, REFILL} state_e;

  state_e                state_q, state_d;
  logic [PLEN-1:0]       paddr_q, paddr_d;
  logic [WAY_WIDTH-1:0]  way_q, way_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic                  err_q, err_d;
  logic [31:0]           count_q, count_d;
  logic                  last_beat;

  assign last_beat = (beat_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d          = state_q;
    paddr_d          = paddr_q;
    way_d            = way_q;
    line_d           = line_q;
    beat_d           = beat_q;
    err_d            = err_q;
    count_d          = count_q;
    miss_req_ready_o = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_rsp_ready_o  = 1'b0;
    refill_valid_o   = 1'b0;

    case (state_q)
      IDLE: begin
        miss_req_ready_o = 1'b1;
        if (miss_req_valid_i) begin
          paddr_d = {miss_req_paddr_i[PLEN-1:OFF_W], OFF_W'(0)};
          way_d   = miss_req_victim_way_i;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == CNT_W'(k)) begin
              line_d[k*BUS_WIDTH +: BUS_WIDTH] = mem_rsp_data_i;
            end
          end
          // A misplaced or missing last flag is only flagged; the beat count decides the end.
          if (mem_rsp_last_i != last_beat) begin
            err_d = 1'b1;
          end
          beat_d = beat_q + CNT_W'(1);
          if (last_beat) begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) begin
          count_d = count_q + 32'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      paddr_q <= '0;
      way_q   <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      way_q   <= way_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign mem_req_addr_o = paddr_q;
  assign refill_paddr_o = paddr_q;
  assign refill_way_o   = way_q;
  assign refill_data_o  = line_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;
  assign refill_count_o = count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_icache_refill_ctrl;

  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         miss_req_valid_i;
  logic         miss_req_ready_o;
  logic [31:0]  miss_req_paddr_i;
  logic [1:0]   miss_req_victim_way_i;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic         mem_rsp_ready_o;
  logic [63:0]  mem_rsp_data_i;
  logic         mem_rsp_last_i;
  logic         refill_valid_o;
  logic         refill_ready_i;
  logic [31:0]  refill_paddr_o;
  logic [1:0]   refill_way_o;
  logic [255:0] refill_data_o;
  logic         busy_o;
  logic         err_o;
  logic [31:0]  refill_count_o;

  icache_refill_ctrl dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .miss_req_valid_i     (miss_req_valid_i),
    .miss_req_ready_o     (miss_req_ready_o),
    .miss_req_paddr_i     (miss_req_paddr_i),
    .miss_req_victim_way_i(miss_req_victim_way_i),
    .mem_req_valid_o      (mem_req_valid_o),
    .mem_req_ready_i      (mem_req_ready_i),
    .mem_req_addr_o       (mem_req_addr_o),
    .mem_rsp_valid_i      (mem_rsp_valid_i),
    .mem_rsp_ready_o      (mem_rsp_ready_o),
    .mem_rsp_data_i       (mem_rsp_data_i),
    .mem_rsp_last_i       (mem_rsp_last_i),
    .refill_valid_o       (refill_valid_o),
    .refill_ready_i       (refill_ready_i),
    .refill_paddr_o       (refill_paddr_o),
    .refill_way_o         (refill_way_o),
    .refill_data_o        (refill_data_o),
    .busy_o               (busy_o),
    .err_o                (err_o),
    .refill_count_o       (refill_count_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        errModel = 1'b0;
  logic [31:0] countModel = 32'd0;

  typedef struct {
    logic [31:0] paddr;
    logic [1:0]  way;
    int          memWait;
    int          refWait;
    int          badBeat;
    logic [63:0] base;
    logic [31:0] expAddr;
    logic        expErr;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkIdle();
    checkOutput("idle_miss_ready", miss_req_ready_o, 1'b1);
    checkOutput("idle_busy", busy_o, 1'b0);
    checkOutput("idle_mem_req_valid", mem_req_valid_o, 1'b0);
    checkOutput("idle_rsp_ready", mem_rsp_ready_o, 1'b0);
    checkOutput("idle_refill_valid", refill_valid_o, 1'b0);
  endtask

  task automatic grantMem();
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
  endtask

  task automatic sendBeat(input logic [63:0] data, input logic last);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = data;
    mem_rsp_last_i  = last;
    tick();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
  endtask

  // One full miss transaction with chosen stalls; every cycle checked against the protocol rules.
  task automatic applyStimulus(input logic [31:0] paddr, input logic [1:0] way, input int memWait,
                               input int refWait, input int badBeat, input logic [63:0] base,
                               input logic [31:0] expAddr, input int maxGap);
    logic [255:0] expLine;
    logic [63:0]  beat;
    int           lat;
    int           expLat;
    int           gap;
    expLine = '0;
    expLat  = 2 + memWait + BEATS;
    checkIdle();
    miss_req_valid_i      = 1'b1;
    miss_req_paddr_i      = paddr;
    miss_req_victim_way_i = way;
    tick();
    lat = 1;
    miss_req_valid_i = 1'b0;
    checkOutput("req_valid", mem_req_valid_o, 1'b1);
    checkOutput("req_addr", mem_req_addr_o, expAddr);
    checkOutput("busy", busy_o, 1'b1);
    checkOutput("miss_ready_busy", miss_req_ready_o, 1'b0);
    for (int i = 0; i < memWait; i++) begin
      mem_rsp_valid_i  = 1'($urandom_range(0, 1));
      mem_rsp_data_i   = {$urandom, $urandom};
      miss_req_valid_i = 1'($urandom_range(0, 1));
      miss_req_paddr_i = $urandom;
      tick();
      lat++;
      checkOutput("req_valid_hold", mem_req_valid_o, 1'b1);
      checkOutput("req_addr_hold", mem_req_addr_o, expAddr);
      checkOutput("rsp_ready_in_req", mem_rsp_ready_o, 1'b0);
    end
    mem_rsp_valid_i  = 1'b0;
    miss_req_valid_i = 1'b0;
    grantMem();
    lat++;
    checkOutput("req_valid_drop", mem_req_valid_o, 1'b0);
    checkOutput("rsp_ready_fill", mem_rsp_ready_o, 1'b1);
    for (int k = 0; k < BEATS; k++) begin
      gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      expLat += gap;
      for (int g = 0; g < gap; g++) begin
        tick();
        lat++;
        checkOutput("rsp_ready_gap", mem_rsp_ready_o, 1'b1);
        checkOutput("refill_valid_gap", refill_valid_o, 1'b0);
      end
      beat = base * 64'(k + 1);
      expLine[k*64 +: 64] = beat;
      sendBeat(beat, (k == BEATS - 1) ^ (k == badBeat));
      lat++;
      if (k == badBeat) errModel = 1'b1;
      checkOutput("err_after_beat", err_o, errModel);
    end
    checkOutput("refill_latency", lat, expLat);
    checkOutput("refill_valid", refill_valid_o, 1'b1);
    checkOutput("refill_paddr", refill_paddr_o, expAddr);
    checkOutput("refill_way", refill_way_o, way);
    checkOutput("refill_data", refill_data_o, expLine);
    checkOutput("rsp_ready_refill", mem_rsp_ready_o, 1'b0);
    for (int r = 0; r < refWait; r++) begin
      mem_rsp_valid_i  = 1'($urandom_range(0, 1));
      mem_rsp_data_i   = {$urandom, $urandom};
      miss_req_valid_i = 1'($urandom_range(0, 1));
      tick();
      checkOutput("refill_valid_hold", refill_valid_o, 1'b1);
      checkOutput("refill_data_hold", refill_data_o, expLine);
      checkOutput("refill_paddr_hold", refill_paddr_o, expAddr);
      checkOutput("refill_way_hold", refill_way_o, way);
      checkOutput("miss_ready_refill", miss_req_ready_o, 1'b0);
      checkOutput("count_hold", refill_count_o, countModel);
    end
    mem_rsp_valid_i  = 1'b0;
    miss_req_valid_i = 1'b0;
    refill_ready_i   = 1'b1;
    tick();
    refill_ready_i = 1'b0;
    countModel++;
    checkOutput("refill_count", refill_count_o, countModel);
    checkOutput("err_end", err_o, errModel);
    checkIdle();
  endtask

  initial begin
    logic [31:0] rpaddr;
    int          rbad;

    vecs[0] = '{32'h8000_0014, 2'd2, 0, 0, -1, 64'h1111_1111_1111_1111, 32'h8000_0000, 1'b0};
    vecs[1] = '{32'h1234_567F, 2'd1, 5, 3, -1, 64'h0102_0304_0506_0708, 32'h1234_5660, 1'b0};
    vecs[2] = '{32'h0000_0020, 2'd3, 0, 0,  1, 64'h0A0B_0C0D_0E0F_1011, 32'h0000_0020, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 2'd0, 1, 1, -1, 64'h5555_0000_AAAA_0001, 32'hFFFF_FFE0, 1'b1};
    vecs[4] = '{32'h0000_001F, 2'd2, 2, 0,  3, 64'h0000_0001_0000_0003, 32'h0000_0000, 1'b1};

    rst_i                 = 1'b1;
    miss_req_valid_i      = 1'b0;
    miss_req_paddr_i      = '0;
    miss_req_victim_way_i = '0;
    mem_req_ready_i       = 1'b0;
    mem_rsp_valid_i       = 1'b0;
    mem_rsp_data_i        = '0;
    mem_rsp_last_i        = 1'b0;
    refill_ready_i        = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    $display("[TB] reset state");
    checkIdle();
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_count", refill_count_o, 32'd0);
    checkOutput("rst_data", refill_data_o, 256'd0);
    checkOutput("rst_addr", mem_req_addr_o, 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].paddr, vecs[i].way, vecs[i].memWait, vecs[i].refWait,
                    vecs[i].badBeat, vecs[i].base, vecs[i].expAddr, 0);
      checkOutput("vec_err", err_o, vecs[i].expErr);
    end

    // Miss valid held high: second address accepted right after the first refill handshake.
    $display("[TB] back-to-back misses");
    miss_req_valid_i      = 1'b1;
    miss_req_paddr_i      = 32'h4000_0048;
    miss_req_victim_way_i = 2'd1;
    tick();
    miss_req_paddr_i      = 32'h5000_00C7;
    miss_req_victim_way_i = 2'd3;
    checkOutput("b2b_first_addr", mem_req_addr_o, 32'h4000_0040);
    grantMem();
    for (int k = 0; k < BEATS; k++) sendBeat(64'(k + 1), k == BEATS - 1);
    checkOutput("b2b_refill_valid", refill_valid_o, 1'b1);
    checkOutput("b2b_refill_way", refill_way_o, 2'd1);
    checkOutput("b2b_no_accept", miss_req_ready_o, 1'b0);
    refill_ready_i = 1'b1;
    tick();
    refill_ready_i = 1'b0;
    countModel++;
    checkOutput("b2b_ready_after", miss_req_ready_o, 1'b1);
    checkOutput("b2b_count1", refill_count_o, countModel);
    tick();
    miss_req_valid_i = 1'b0;
    checkOutput("b2b_second_req", mem_req_valid_o, 1'b1);
    checkOutput("b2b_second_addr", mem_req_addr_o, 32'h5000_00C0);
    grantMem();
    for (int k = 0; k < BEATS; k++) sendBeat(64'(k + 9), k == BEATS - 1);
    checkOutput("b2b_second_way", refill_way_o, 2'd3);
    refill_ready_i = 1'b1;
    tick();
    refill_ready_i = 1'b0;
    countModel++;
    checkOutput("b2b_count2", refill_count_o, countModel);

    $display("[TB] reset in FILL");
    miss_req_valid_i      = 1'b1;
    miss_req_paddr_i      = 32'h0000_1234;
    miss_req_victim_way_i = 2'd2;
    tick();
    miss_req_valid_i = 1'b0;
    grantMem();
    sendBeat(64'hDEAD_BEEF_0000_0001, 1'b0);
    sendBeat(64'hDEAD_BEEF_0000_0002, 1'b0);
    rst_i           = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'hDEAD_BEEF_0000_0003;
    tick();
    rst_i      = 1'b0;
    errModel   = 1'b0;
    countModel = 32'd0;
    checkIdle();
    checkOutput("abort_err", err_o, 1'b0);
    checkOutput("abort_count", refill_count_o, 32'd0);
    checkOutput("abort_data", refill_data_o, 256'd0);
    checkOutput("abort_paddr", refill_paddr_o, 32'd0);
    checkOutput("abort_way", refill_way_o, 2'd0);
    for (int i = 0; i < 4; i++) begin
      mem_rsp_last_i = 1'(i == 1);
      tick();
      checkOutput("abort_no_refill", refill_valid_o, 1'b0);
      checkOutput("abort_err_clean", err_o, 1'b0);
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;

    $display("[TB] reset beats simultaneous miss handshake");
    miss_req_valid_i = 1'b1;
    rst_i            = 1'b1;
    tick();
    rst_i            = 1'b0;
    miss_req_valid_i = 1'b0;
    checkIdle();

    $display("[TB] refill counter wrap");
    force dut.count_q = 32'hFFFF_FFFF;
    tick();
    release dut.count_q;
    countModel = 32'hFFFF_FFFF;
    checkOutput("wrap_preload", refill_count_o, countModel);
    applyStimulus(32'h2000_0000, 2'd0, 0, 0, -1, 64'h1, 32'h2000_0000, 0);
    checkOutput("wrap_zero", refill_count_o, 32'd0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 25; n++) begin
      rpaddr = $urandom;
      rbad   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
      applyStimulus(rpaddr, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), rbad, {$urandom, $urandom},
                    {rpaddr[31:5], 5'b0}, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter PLEN, default 32, physical address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 256, ICache line width in bits.
REQ-003 SHALL have parameter BUS_WIDTH, default 64, memory data beat width; BEATS = LINE_WIDTH/BUS_WIDTH (default 4).
REQ-004 SHALL have parameter WAY_WIDTH, default 2, victim-way index width.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports miss_req_valid_i in 1, miss_req_ready_o out 1, miss_req_paddr_i in PLEN, miss_req_victim_way_i in WAY_WIDTH: miss request from the ICache.
REQ-008 SHALL have ports mem_req_valid_o out 1, mem_req_ready_i in 1, mem_req_addr_o out PLEN: line-read request to memory.
REQ-009 SHALL have ports mem_rsp_valid_i in 1, mem_rsp_ready_o out 1, mem_rsp_data_i in BUS_WIDTH, mem_rsp_last_i in 1: read-data beats.
REQ-010 SHALL have ports refill_valid_o out 1, refill_ready_i in 1, refill_paddr_o out PLEN, refill_way_o out WAY_WIDTH, refill_data_o out LINE_WIDTH: refill to the ICache.
REQ-011 SHALL have ports busy_o out 1 (state != IDLE), err_o out 1 (sticky protocol error), refill_count_o out 32 (completed refills).

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> FILL -> REFILL -> IDLE; no other states.
REQ-013 IDLE: miss_req_ready_o=1; on valid&ready capture paddr and way, go REQ next cycle; ready_o=0 in all other states.
REQ-014 Captured address SHALL be line-aligned: low log2(LINE_WIDTH/8) bits (5 by default) forced to 0; refill_paddr_o and mem_req_addr_o carry the aligned value.
REQ-015 REQ: mem_req_valid_o=1, addr held stable until mem_req_ready_i; on handshake go FILL, clear beat counter.
REQ-016 FILL: mem_rsp_ready_o=1; each accepted beat k written to line bits [k*BUS_WIDTH +: BUS_WIDTH], counter increments.
REQ-017 On acceptance of beat BEATS-1, go REFILL next cycle; beats arriving outside FILL are not accepted (ready_o=0).
REQ-018 mem_rsp_last_i asserted on beat k != BEATS-1, or deasserted on beat BEATS-1, SHALL set err_o (sticky until reset); FSM still counts exactly BEATS beats.
REQ-019 REFILL: refill_valid_o=1, paddr/way/data held stable until refill_ready_i; on handshake refill_count_o increments (wraps 2^32-1 -> 0) and go IDLE.
REQ-020 Minimum latency: miss accepted cycle 0, mem_req_valid_o cycle 1; with zero-wait memory, refill_valid_o at cycle 2+BEATS (cycle 6 default).
REQ-021 New miss SHALL be accepted no earlier than the cycle after the refill handshake (one outstanding miss only).
REQ-022 Valid outputs SHALL not depend combinationally on the corresponding ready inputs.

Reset
REQ-023 rst_i SHALL force IDLE; miss_req_ready_o=1 the cycle after release; all other outputs, line buffer, beat counter, err_o, refill_count_o = 0.
REQ-024 rst_i mid-transaction (any state) SHALL abort it: partial line dropped, no refill_valid_o issued, beats still in flight ignored.
REQ-025 rst_i takes priority over every simultaneous handshake in the same cycle.

Verification
REQ-026 Miss paddr 0x8000_0014 way 2, zero-wait memory, beats 0x11..,0x22..,0x33..,0x44.. with last on beat 3 -> mem_req_addr_o 0x8000_0000, refill at cycle 6, data {beat3,beat2,beat1,beat0}, way 2, count 1, err_o 0.
REQ-027 mem_req_ready_i held low 5 cycles, refill_ready_i low 3 cycles -> valids and payloads stable throughout, exactly one refill, count 1.
REQ-028 mem_rsp_last_i on beat 1 -> err_o=1 from next cycle, refill still after 4th beat with all 4 beats, err_o stays 1 through following clean miss.
REQ-029 miss_req_valid_i held high continuously with two addresses -> second accepted cycle after first refill handshake, count 2.
REQ-030 rst_i asserted after 2 beats in FILL -> next cycle IDLE, all outputs 0 except miss_req_ready_o=1, no refill_valid_o, count 0.
REQ-031 refill_count_o preloaded (via forced state) to 0xFFFF_FFFF plus one refill -> 0x0000_0000.
